bldc_adc_resp: RTL and testbench
================================

Name: bldc_adc_resp

Overview:
- ADC command responder for the BLDC ADC interface. It accepts channel commands from the BLDC ADC controller over a valid/ready command channel.
- For each command it runs SPI frames to an external 8-channel, 12-bit serial ADC (address-pipelined, 16-SCLK frame).
- It returns one response beat per command carrying the channel and the 12-bit sample.
- It sits between the bldc_adc_ctrl command/response ports and the chip pins.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (legal range 2..255)
- NUM_CH, 8, number of physical ADC channels (addresses 0..NUM_CH-1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_vld_i  in  1  command valid
- cmd_ch_i  in  5  command channel
- cmd_sop_i  in  1  ignored
- cmd_eop_i  in  1  ignored
- cmd_ready_o  out  1  command ready
- rsp_vld_o  out  1  response valid, 1-cycle pulse
- rsp_sop_o  out  1  equals rsp_vld_o
- rsp_eop_o  out  1  equals rsp_vld_o
- rsp_ch_o  out  5  response channel
- rsp_data_o  out  12  response data
- adc_cs_n_o  out  1  ADC chip select, active-low
- adc_sclk_o  out  1  ADC serial clock, idles high
- adc_din_o  out  1  ADC address serial data in
- adc_dout_i  in  1  ADC serial data out (already synchronised externally)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: cmd_ready_o=0, rsp_vld_o/sop/eop=0, rsp_ch_o=0, rsp_data_o=0, adc_cs_n_o=1, adc_sclk_o=1, adc_din_o=0.
- Internal reset values: last_addr=0, last_addr_vld=0, state=IDLE. cmd_ready_o rises the cycle after rst deasserts.
- Handshake: a command is accepted when cmd_vld_i & cmd_ready_o. cmd_ready_o is high only in IDLE and drops the cycle after acceptance. Channel is latched as req_ch.
- Address: phys_addr = req_ch[2:0].
- Frame count per command:
  - If last_addr_vld & last_addr==phys_addr: one DATA frame.
  - Otherwise: a PRIME frame (DOUT discarded) followed by a DATA frame.
  - Both frames shift address phys_addr. After any frame, last_addr=phys_addr and last_addr_vld=1.
- States: IDLE -> SETUP -> SHIFT -> GAP -> (PRIME done: SETUP | DATA done: IDLE).
- SETUP: cs_n low, sclk high, CLK_DIV cycles.
- SHIFT: 32 half-periods of CLK_DIV cycles each. Each SCLK bit k=0..15 is a falling edge then a rising edge.
  - adc_din_o updates on the falling edge: bits k=2,3,4 carry phys_addr[2], [1], [0]; all other bits drive 0.
  - adc_dout_i is sampled at rising edges k=4..15 into a 12-bit shift register, MSB first.
- GAP: cs_n high, sclk high, CLK_DIV cycles (quiet time).
- Timing: frame = 34*CLK_DIV cycles.
- Response: on the first GAP cycle of a DATA frame, rsp_vld/sop/eop pulse for 1 cycle. rsp_ch_o=req_ch (full 5 bits) and rsp_data_o=shift register.
- rsp_ch_o/rsp_data_o hold their value until the next response.
- No response backpressure. Every response is issued unconditionally.
- Latency from acceptance to rsp_vld_o, CLK_DIV=4:
  - single frame: 1+4+128 = 133 cycles
  - primed: 133+136 = 269 cycles
- cmd_vld_i and cmd_ch_i are ignored outside IDLE.
- Reset mid-frame: the cycle after rst, all outputs return to reset values, no response is issued, and last_addr_vld=0.

Optional Feature:
- Macro: BLDC_ADC_RANGE_CHK_EN.
- Defined: an accepted command with cmd_ch_i >= NUM_CH runs no frame. It produces a response 2 cycles after acceptance with rsp_ch_o=cmd_ch_i and rsp_data_o=12'hFFF, and last_addr is untouched.
- Undefined: the channel is truncated to [2:0] and converted normally, with rsp_ch_o still reporting the full 5-bit value.

Test Plan:
- Reset release, cmd_vld_i=1, ch=3, ADC model returns 12'hA5C -> prime + data frames. din bits 2..4 = 0,1,1 in both frames; one rsp_vld pulse 269 cycles after acceptance with ch=3, data=12'hA5C.
- Back-to-back ch=3 after the above -> single frame, rsp at 133 cycles, no prime frame.
- Round-robin ch 0..5 as driven by bldc_adc_ctrl, model data = 12'h100+ch -> six responses in order, each with data=12'h100+ch. cmd_ready_o is never high during a frame.
- CLK_DIV=2 build -> SCLK period 4 cycles, frame 68 cycles, cs_n high for exactly 2 cycles between frames.
- rst asserted in SHIFT bit 9 -> next cycle cs_n=1, sclk=1, no rsp. A following ch=3 command is primed again.
- ch=12 with BLDC_ADC_RANGE_CHK_EN -> no cs_n activity, rsp ch=12, data=12'hFFF 2 cycles after acceptance. Without the macro: address 4 is shifted and rsp ch=12.

Source files
------------

// File: rtl/bldc_adc_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : bldc_adc_resp_if
// Brief    : Command/response channel between bldc_adc_ctrl and the ADC
//            responder. The controller is the master; the responder is the slave.
// Revision : 1.0
// ============================================================================
interface bldc_adc_resp_if;
    // Command channel (valid/ready)
    logic        cmd_vld_i;
    logic [4:0]  cmd_ch_i;
    logic        cmd_sop_i;
    logic        cmd_eop_i;
    logic        cmd_ready_o;
    // Response channel (single-beat pulse, no backpressure)
    logic        rsp_vld_o;
    logic        rsp_sop_o;
    logic        rsp_eop_o;
    logic [4:0]  rsp_ch_o;
    logic [11:0] rsp_data_o;

    modport master (
        output cmd_vld_i, cmd_ch_i, cmd_sop_i, cmd_eop_i,
        input  cmd_ready_o,
        input  rsp_vld_o, rsp_sop_o, rsp_eop_o, rsp_ch_o, rsp_data_o
    );

    modport slave (
        input  cmd_vld_i, cmd_ch_i, cmd_sop_i, cmd_eop_i,
        output cmd_ready_o,
        output rsp_vld_o, rsp_sop_o, rsp_eop_o, rsp_ch_o, rsp_data_o
    );
endinterface
`default_nettype wire

// File: rtl/bldc_adc_resp.sv
`default_nettype none
// ============================================================================
// Module   : bldc_adc_resp
// Brief    : Takes channel commands, runs 16-SCLK address-pipelined SPI frames
//            to an 8-channel 12-bit ADC (priming with an extra frame whenever
//            the addressed channel changes) and returns one response per
//            command. Optional macro BLDC_ADC_RANGE_CHK_EN answers channels
//            >= NUM_CH with 12'hFFF without touching the ADC.
// Revision : 1.0
// ============================================================================
module bldc_adc_resp #(
    parameter int CLK_DIV = 4,   // clk cycles per SCLK half-period (2..255)
    parameter int NUM_CH  = 8    // physical ADC channels
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bldc_adc_resp_if.slave   bus,
    output logic             adc_cs_n_o,
    output logic             adc_sclk_o,
    output logic             adc_din_o,
    input  wire logic        adc_dout_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);

    state_t       r_state, w_state_nxt;
    logic [7:0]   r_cnt, w_cnt_nxt;         // cycles within phase / half-period
    logic [4:0]   r_half, w_half_nxt;       // SCLK half-period index 0..31
    logic         r_prime, w_prime_nxt;     // current frame is a priming frame
    logic [4:0]   r_req_ch, w_req_ch_nxt;
    logic [2:0]   r_last_addr;
    logic         r_last_vld;
    logic [11:0]  r_shift;
    logic         r_cmd_ready;
    logic         r_rsp_vld;
    logic [4:0]   r_rsp_ch;
    logic [11:0]  r_rsp_data;
    logic         r_cs_n, r_sclk, r_din;
    logic         w_cs_n_nxt, w_sclk_nxt, w_din_nxt;

    wire logic w_accept    = (r_state == S_IDLE) & bus.cmd_vld_i & r_cmd_ready;
    wire logic w_cnt_end   = (r_cnt == C_DIV_LAST);
    wire logic w_frame_end = (r_state == S_SHIFT) & w_cnt_end & (r_half == 5'd31);
    wire logic w_ch_oor    = (32'(bus.cmd_ch_i) >= NUM_CH);
    // Rising SCLK at the end of an even half-period; data bits live in k=4..15
    wire logic w_sample    = (r_state == S_SHIFT) & w_cnt_end & ~r_half[0]
                             & (r_half[4:1] >= 4'd4);

`ifdef BLDC_ADC_RANGE_CHK_EN
    wire logic w_range_err = w_ch_oor;
`else
    wire logic w_range_err = 1'b0;
`endif

    // Framing bits carry no meaning for single-beat commands
    wire logic w_unused = &{1'b0, bus.cmd_sop_i, bus.cmd_eop_i, w_ch_oor};

    // Next-state, counters and next pin values
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_half_nxt   = r_half;
        w_prime_nxt  = r_prime;
        w_req_ch_nxt = r_req_ch;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 8'd0;
                if (w_accept) begin
                    w_req_ch_nxt = bus.cmd_ch_i;
                    if (w_range_err) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_SETUP;
                        // ADC returns the previous frame's channel, so a new
                        // address needs one discarded frame first
                        w_prime_nxt = ~(r_last_vld & (r_last_addr == bus.cmd_ch_i[2:0]));
                    end
                end
            end
            S_SETUP: begin
                if (w_cnt_end) begin
                    w_cnt_nxt   = 8'd0;
                    w_half_nxt  = 5'd0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_SHIFT: begin
                if (w_cnt_end) begin
                    w_cnt_nxt = 8'd0;
                    if (r_half == 5'd31) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_half_nxt = r_half + 5'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_GAP: begin
                if (w_cnt_end) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = r_prime ? S_SETUP : S_IDLE;
                    w_prime_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        w_cs_n_nxt = ~((w_state_nxt == S_SETUP) | (w_state_nxt == S_SHIFT));
        // Even half-periods are SCLK low (falling edge starts each bit)
        w_sclk_nxt = ~((w_state_nxt == S_SHIFT) & ~w_half_nxt[0]);
        w_din_nxt  = 1'b0;
        if (w_state_nxt == S_SHIFT) begin
            case (w_half_nxt[4:1])
                4'd2:    w_din_nxt = r_req_ch[2];
                4'd3:    w_din_nxt = r_req_ch[1];
                4'd4:    w_din_nxt = r_req_ch[0];
                default: w_din_nxt = 1'b0;
            endcase
        end
    end

    // FSM and sequencing registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_half   <= 5'd0;
            r_prime  <= 1'b0;
            r_req_ch <= 5'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_half   <= w_half_nxt;
            r_prime  <= w_prime_nxt;
            r_req_ch <= w_req_ch_nxt;
        end
    end

    // Pins, sample shift register, address history and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b0;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b1;
            r_din       <= 1'b0;
            r_shift     <= 12'd0;
            r_last_addr <= 3'd0;
            r_last_vld  <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_ch    <= 5'd0;
            r_rsp_data  <= 12'd0;
        end else begin
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_cs_n      <= w_cs_n_nxt;
            r_sclk      <= w_sclk_nxt;
            r_din       <= w_din_nxt;
            if (w_sample) begin
                r_shift <= {r_shift[10:0], adc_dout_i};
            end
            if (w_frame_end) begin
                r_last_addr <= r_req_ch[2:0];
                r_last_vld  <= 1'b1;
            end
            r_rsp_vld <= (w_frame_end & ~r_prime) | (r_state == S_ERR);
            if (w_frame_end & ~r_prime) begin
                r_rsp_ch   <= r_req_ch;
                r_rsp_data <= r_shift;
            end else if (r_state == S_ERR) begin
                r_rsp_ch   <= r_req_ch;
                r_rsp_data <= 12'hFFF;
            end
        end
    end

    assign bus.cmd_ready_o = r_cmd_ready;
    assign bus.rsp_vld_o   = r_rsp_vld;
    assign bus.rsp_sop_o   = r_rsp_vld;
    assign bus.rsp_eop_o   = r_rsp_vld;
    assign bus.rsp_ch_o    = r_rsp_ch;
    assign bus.rsp_data_o  = r_rsp_data;
    assign adc_cs_n_o      = r_cs_n;
    assign adc_sclk_o      = r_sclk;
    assign adc_din_o       = r_din;

endmodule
`default_nettype wire

// File: tb/tb_bldc_adc_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_bldc_adc_resp
// Brief    : Scoreboard bench for bldc_adc_resp with a behavioural
//            address-pipelined 12-bit serial ADC model.
// Revision : 1.0
// ============================================================================
module tb_bldc_adc_resp;

    localparam int DIV  = 4;
    localparam int LAT1 = 1 + DIV + 32 * DIV;     // single frame
    localparam int LAT2 = LAT1 + 34 * DIV;        // primed

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic adc_cs_n, adc_sclk, adc_din;
    logic adc_dout = 1'b0;

    bldc_adc_resp_if u_if ();

    bldc_adc_resp #(.CLK_DIV(DIV), .NUM_CH(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (u_if),
        .adc_cs_n_o (adc_cs_n),
        .adc_sclk_o (adc_sclk),
        .adc_din_o  (adc_din),
        .adc_dout_i (adc_dout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [4:0]  ch;
        logic [11:0] data;
        int          acc;
        int          lat;
    } rsp_t;

    rsp_t       q_rsp[$];
    logic [2:0] q_frame[$];
    rsp_t       mon_e;
    int         rdy_viol = 0;
    int         sop_viol = 0;
    int         exp_cs   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.rsp_vld_o === 1'b1) begin
                if (q_rsp.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    mon_e = q_rsp.pop_front();
                    check("rsp_ch", u_if.rsp_ch_o, mon_e.ch);
                    check("rsp_data", u_if.rsp_data_o, mon_e.data);
                    check("rsp_latency", cyc - mon_e.acc, mon_e.lat);
                end
            end
            if (u_if.rsp_sop_o !== u_if.rsp_vld_o || u_if.rsp_eop_o !== u_if.rsp_vld_o)
                sop_viol++;
            if (u_if.cmd_ready_o === 1'b1 && adc_cs_n === 1'b0)
                rdy_viol++;
        end
    end

    // ---------------- ADC model ----------------
    logic [11:0] adc_val[8];
    logic [2:0]  mdl_prev = 3'd0;
    logic [2:0]  mdl_exp;
    logic [15:0] mdl_din  = 16'd0;
    logic        cs_prev, sclk_prev;
    int          mdl_bit  = 0;
    int          n_cs_fall = 0;

    always @(adc_cs_n or adc_sclk) begin
        if (cs_prev === 1'b1 && adc_cs_n === 1'b0) begin
            mdl_bit = 0;
            mdl_din = 16'd0;
            n_cs_fall++;
        end
        if (cs_prev === 1'b0 && adc_cs_n === 1'b1 && mdl_bit == 16) begin
            if (q_frame.size() == 0) begin
                check("frame_unexpected", 1, 0);
            end else begin
                mdl_exp = q_frame.pop_front();
                check("frame_din", mdl_din, {2'b00, mdl_exp, 11'b0});
            end
            mdl_prev = mdl_din[13:11];
        end
        if (adc_cs_n === 1'b0 && sclk_prev === 1'b1 && adc_sclk === 1'b0) begin
            adc_dout = (mdl_bit >= 4 && mdl_bit < 16) ? adc_val[mdl_prev][15 - mdl_bit] : 1'b0;
            mdl_bit++;
        end
        if (adc_cs_n === 1'b0 && sclk_prev === 1'b0 && adc_sclk === 1'b1
            && mdl_bit >= 1 && mdl_bit <= 16) begin
            mdl_din[16 - mdl_bit] = adc_din;
        end
        cs_prev   = adc_cs_n;
        sclk_prev = adc_sclk;
    end

    // ---------------- driver ----------------
    task automatic send(input logic [4:0] ch, input logic [11:0] data, input int lat,
                        input int nframes, input bit exp_rsp);
        int waited = 0;
        u_if.cmd_ch_i  = ch;
        u_if.cmd_vld_i = 1'b1;
        while (u_if.cmd_ready_o !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            check("cmd_accept_timeout", 0, 1);
            u_if.cmd_vld_i = 1'b0;
            return;
        end
        if (exp_rsp) q_rsp.push_back('{ch, data, cyc, lat});
        for (int i = 0; i < nframes; i++) q_frame.push_back(ch[2:0]);
        exp_cs += nframes;
        @(negedge clk);
        u_if.cmd_vld_i = 1'b0;
        u_if.cmd_ch_i  = 5'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q_rsp.size() != 0 || q_frame.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("drain_timeout", q_rsp.size() + q_frame.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        u_if.cmd_vld_i = 1'b0;
        u_if.cmd_ch_i  = 5'd0;
        u_if.cmd_sop_i = 1'b0;
        u_if.cmd_eop_i = 1'b0;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h300 + 12'(i);

        repeat (3) @(negedge clk);
        check("rst_ready", u_if.cmd_ready_o, 0);
        check("rst_rsp_vld", u_if.rsp_vld_o, 0);
        check("rst_rsp_ch", u_if.rsp_ch_o, 0);
        check("rst_rsp_data", u_if.rsp_data_o, 0);
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_din", adc_din, 0);
        rst = 1'b0;
        check("ready_release", u_if.cmd_ready_o, 0);
        @(negedge clk);
        check("ready_after_release", u_if.cmd_ready_o, 1);

        // First conversion of channel 3: primed
        adc_val[3] = 12'hA5C;
        send(5'd3, 12'hA5C, LAT2, 2, 1'b1);
        wait_done();

        // Same channel again: single frame
        send(5'd3, 12'hA5C, LAT1, 1, 1'b1);
        wait_done();

        // Round-robin 0..5
        for (int i = 0; i < 6; i++) adc_val[i] = 12'h100 + 12'(i);
        for (int i = 0; i < 6; i++) send(5'(i), 12'h100 + 12'(i), LAT2, 2, 1'b1);
        wait_done();
        repeat (5) @(negedge clk);
        check("rsp_ch_hold", u_if.rsp_ch_o, 5);
        check("rsp_data_hold", u_if.rsp_data_o, 12'h105);

        // Reset in the middle of a frame (bit 9 of a single frame)
        adc_val[3] = 12'h5C3;
        send(5'd3, 12'h5C3, LAT2, 2, 1'b1);
        wait_done();
        send(5'd3, 12'h5C3, 0, 0, 1'b0);
        exp_cs += 1;
        repeat (78) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs_n", adc_cs_n, 1);
        check("midrst_sclk", adc_sclk, 1);
        check("midrst_din", adc_din, 0);
        check("midrst_rsp_vld", u_if.rsp_vld_o, 0);
        check("midrst_ready", u_if.cmd_ready_o, 0);
        rst = 1'b0;
        @(negedge clk);
        send(5'd3, 12'h5C3, LAT2, 2, 1'b1);
        wait_done();

        // Out-of-range channel
        adc_val[4] = 12'h7E4;
`ifdef BLDC_ADC_RANGE_CHK_EN
        send(5'd12, 12'hFFF, 2, 0, 1'b1);
        wait_done();
        send(5'd3, 12'h5C3, LAT1, 1, 1'b1);
`else
        send(5'd12, 12'h7E4, LAT2, 2, 1'b1);
        wait_done();
        send(5'd3, 12'h5C3, LAT2, 2, 1'b1);
`endif
        wait_done();

        check("ready_during_frame", rdy_viol, 0);
        check("sop_eop_track_vld", sop_viol, 0);
        check("cs_frame_count", n_cs_fall, exp_cs);
        check("rsp_queue_empty", q_rsp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
